// File: rtl/clock_mode_ctrl.sv
// Button-driven control sequencer for the digital clock: mode selection, edit cursor,
// stopwatch/timer run state, alarm timeout and the 1-second tick. Holds no time values.
module clock_mode_ctrl #(
  parameter int TICK_DIV  = 100,
  parameter int ALARM_SEC = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_mode,
  input  logic       i_set,
  input  logic       i_tmr_zero,
  output logic [1:0] o_mode,
  output logic       o_editing,
  output logic [1:0] o_field,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_tick,
  output logic       o_sw_run,
  output logic       o_sw_lap,
  output logic       o_sw_clear,
  output logic       o_tmr_run,
  output logic       o_tmr_alarm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_MODE  = 4;
  localparam int B_SET   = 5;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SUMMER    = 2'd1,
    MODE_STOPWATCH = 2'd2,
    MODE_TIMER     = 2'd3
  } mode_t;

  mode_t           mode_q, mode_d;
  logic [5:0]      prev_q;
  logic [5:0]      btn;
  logic [5:0]      press;
  logic            any_press;
  logic            mode_win;
  logic            editing_q, editing_d;
  logic [1:0]      field_q, field_d;
  logic            inc_q, inc_d, dec_q, dec_d;
  logic            tick_q, tick_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            sw_run_q, sw_run_d, sw_lap_q, sw_lap_d, sw_clear_q, sw_clear_d;
  logic            tmr_run_q, tmr_run_d, alarm_q, alarm_d;
  logic [AW-1:0]   acnt_q, acnt_d;

  assign btn       = {i_set, i_mode, i_right, i_left, i_down, i_up};
  assign press     = btn & ~prev_q;
  assign any_press = |press;
  assign mode_win  = press[B_MODE] & ~i_set;

  // prev_q resets to all-ones so buttons held through reset never register a press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q     <= '1;
      mode_q     <= MODE_CLOCK;
      editing_q  <= 1'b0;
      field_q    <= 2'd0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      tick_q     <= 1'b0;
      pre_q      <= '0;
      sw_run_q   <= 1'b0;
      sw_lap_q   <= 1'b0;
      sw_clear_q <= 1'b0;
      tmr_run_q  <= 1'b0;
      alarm_q    <= 1'b0;
      acnt_q     <= '0;
    end else begin
      prev_q     <= btn;
      mode_q     <= mode_d;
      editing_q  <= editing_d;
      field_q    <= field_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      tick_q     <= tick_d;
      pre_q      <= pre_d;
      sw_run_q   <= sw_run_d;
      sw_lap_q   <= sw_lap_d;
      sw_clear_q <= sw_clear_d;
      tmr_run_q  <= tmr_run_d;
      alarm_q    <= alarm_d;
      acnt_q     <= acnt_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    editing_d  = i_set & ((mode_q == MODE_CLOCK) | (mode_q == MODE_TIMER));
    field_d    = field_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    tick_d     = 1'b0;
    pre_d      = pre_q;
    sw_run_d   = sw_run_q;
    sw_lap_d   = sw_lap_q;
    sw_clear_d = 1'b0;
    tmr_run_d  = tmr_run_q;
    alarm_d    = alarm_q;
    acnt_d     = acnt_q;

    // Prescaler is parked while the clock is being set so seconds restart from zero
    if (editing_q && (mode_q == MODE_CLOCK)) begin
      pre_d = '0;
    end else if (pre_q == PW'(TICK_DIV - 1)) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (alarm_q && tick_q && (acnt_q != '0)) begin
      acnt_d = acnt_q - 1'b1;
      if (acnt_q == AW'(1)) alarm_d = 1'b0;
    end
    if (any_press) alarm_d = 1'b0;

    if (!editing_q) field_d = 2'd0;

    if (mode_win) begin
      mode_d = mode_t'(mode_q + 2'd1);
      if (mode_q == MODE_STOPWATCH) sw_lap_d = 1'b0;
    end else begin
      if (editing_q) begin
        if (press[B_LEFT] && !press[B_RIGHT])
          field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        else if (press[B_RIGHT] && !press[B_LEFT])
          field_d = (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
        inc_d = press[B_UP] & ~press[B_DOWN];
        dec_d = press[B_DOWN] & ~press[B_UP];
      end

      case (mode_q)
        MODE_STOPWATCH: begin
          if (press[B_SET]) begin
            sw_clear_d = 1'b1;
            sw_run_d   = 1'b0;
            sw_lap_d   = 1'b0;
          end else begin
            if (press[B_UP])   sw_run_d = ~sw_run_q;
            if (press[B_DOWN]) sw_lap_d = ~sw_lap_q;
          end
        end
        MODE_TIMER: begin
          if (!i_set && press[B_UP]) begin
            if (tmr_run_q)        tmr_run_d = 1'b0;
            else if (!i_tmr_zero) tmr_run_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Expiry is checked regardless of mode since the timer keeps counting in the background
    if (tmr_run_q && i_tmr_zero) begin
      tmr_run_d = 1'b0;
      alarm_d   = 1'b1;
      acnt_d    = AW'(ALARM_SEC);
    end

    if (editing_q && (mode_q == MODE_TIMER)) begin
      tmr_run_d = 1'b0;
      alarm_d   = 1'b0;
    end
  end

  assign o_mode      = mode_q;
  assign o_editing   = editing_q;
  assign o_field     = field_q;
  assign o_inc       = inc_q;
  assign o_dec       = dec_q;
  assign o_tick      = tick_q;
  assign o_sw_run    = sw_run_q;
  assign o_sw_lap    = sw_lap_q;
  assign o_sw_clear  = sw_clear_q;
  assign o_tmr_run   = tmr_run_q;
  assign o_tmr_alarm = alarm_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed vector table, hand-written multi-cycle sequences,
// and randomized buttons checked every cycle against a behavioural model.
module tb_clock_mode_ctrl;
  localparam int TICK_DIV  = 10;
  localparam int ALARM_SEC = 5;

  localparam logic [5:0] BT_UP = 6'd1,  BT_DN = 6'd2,  BT_LF = 6'd4;
  localparam logic [5:0] BT_RT = 6'd8,  BT_MD = 6'd16, BT_ST = 6'd32;
  localparam logic [12:0] TICK_BIT = 13'h0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, mode = 1'b0, set = 1'b0;
  logic zero = 1'b0;
  logic [1:0] o_mode, o_field;
  logic o_editing, o_inc, o_dec, o_tick, o_sw_run, o_sw_lap, o_sw_clear, o_tmr_run, o_tmr_alarm;
  logic [12:0] act;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_SEC(ALARM_SEC)) dut (
    .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left), .i_right(right),
    .i_mode(mode), .i_set(set), .i_tmr_zero(zero),
    .o_mode(o_mode), .o_editing(o_editing), .o_field(o_field), .o_inc(o_inc), .o_dec(o_dec),
    .o_tick(o_tick), .o_sw_run(o_sw_run), .o_sw_lap(o_sw_lap), .o_sw_clear(o_sw_clear),
    .o_tmr_run(o_tmr_run), .o_tmr_alarm(o_tmr_alarm)
  );

  assign act = {o_mode, o_editing, o_field, o_inc, o_dec, o_tick,
                o_sw_run, o_sw_lap, o_sw_clear, o_tmr_run, o_tmr_alarm};

  // Behavioural model: mode 0..3 CLOCK/SUMMER/STOPWATCH/TIMER, field 0..2 sec/min/hr
  typedef struct packed {
    int mode; int field; int pre; int acnt;
    bit edit; bit inc; bit dec; bit tick;
    bit swr; bit swl; bit swc; bit tr; bit ta;
    bit [5:0] prev;
  } mstate_t;

  mstate_t mdl;

  function automatic mstate_t step(mstate_t s, bit [5:0] lvl, bit z, bit r);
    mstate_t n;
    bit [5:0] pr;
    bit adv;
    n = s;
    if (r) begin
      n = '0;
      n.prev = '1;
      return n;
    end
    pr  = lvl & ~s.prev;
    adv = pr[4] && !lvl[5];
    n.prev = lvl;
    n.inc = 0; n.dec = 0; n.swc = 0; n.tick = 0;
    n.edit = lvl[5] && (s.mode == 0 || s.mode == 3);
    if (s.edit && s.mode == 0) n.pre = 0;
    else begin
      n.tick = (s.pre == TICK_DIV - 1);
      n.pre  = (s.pre + 1) % TICK_DIV;
    end
    if (s.ta && s.tick && s.acnt > 0) begin
      n.acnt = s.acnt - 1;
      if (n.acnt == 0) n.ta = 0;
    end
    if (pr != 0) n.ta = 0;
    if (!s.edit) n.field = 0;
    if (adv) begin
      n.mode = (s.mode + 1) % 4;
      if (s.mode == 2) n.swl = 0;
    end else begin
      if (s.edit) begin
        if (pr[2] && !pr[3]) n.field = (s.field + 1) % 3;
        if (pr[3] && !pr[2]) n.field = (s.field + 2) % 3;
        n.inc = pr[0] && !pr[1];
        n.dec = pr[1] && !pr[0];
      end
      if (s.mode == 2) begin
        if (pr[5]) begin n.swc = 1; n.swr = 0; n.swl = 0; end
        else begin
          if (pr[0]) n.swr = !s.swr;
          if (pr[1]) n.swl = !s.swl;
        end
      end
      if (s.mode == 3 && !lvl[5] && pr[0]) n.tr = s.tr ? 1'b0 : !z;
    end
    if (s.tr && z) begin n.tr = 0; n.ta = 1; n.acnt = ALARM_SEC; end
    if (s.edit && s.mode == 3) begin n.tr = 0; n.ta = 0; end
    return n;
  endfunction

  always @(posedge clk) mdl <= step(mdl, {set, mode, right, left, down, up}, zero, rst);

  function automatic logic [12:0] modelVec(mstate_t s);
    return {s.mode[1:0], s.edit, s.field[1:0], s.inc, s.dec, s.tick,
            s.swr, s.swl, s.swc, s.tr, s.ta};
  endfunction

  function automatic logic [12:0] ex(int md, int ed, int fd, int inc, int dec,
                                     int swr, int swl, int swc, int tr, int ta);
    return {md[1:0], ed[0], fd[1:0], inc[0], dec[0], 1'b0,
            swr[0], swl[0], swc[0], tr[0], ta[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] b, input logic z, input logic r);
    {set, mode, right, left, down, up} = b;
    zero = z;
    rst  = r;
    @(posedge clk);
    @(negedge clk);
    checkOutput("model", act, modelVec(mdl));
  endtask

  typedef struct packed {
    logic [5:0]  btn;
    logic        zero;
    logic        rst;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int lfSeq[4] = '{1, 2, 0, 1};
  int rtSeq[4] = '{0, 2, 1, 0};

  task automatic addVec(input logic [5:0] b, input logic z, input logic r, input logic [12:0] e);
    vec_t v;
    v.btn = b; v.zero = z; v.rst = r; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [12:0] zv;
    logic [5:0] cur;
    int first, second, nTick, ticks;
    bit done;

    zv = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(BT_UP, 0, 1, zv);
    addVec(BT_UP, 0, 0, zv);
    addVec(6'd0, 0, 0, zv);
    addVec(BT_UP, 0, 0, zv);
    addVec(BT_DN, 0, 0, zv);
    addVec(BT_LF, 0, 0, zv);
    addVec(BT_RT, 0, 0, zv);
    addVec(6'd0, 0, 0, zv);
    addVec(BT_ST, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      addVec(BT_ST | BT_LF, 0, 0, ex(0, 1, lfSeq[i], 0, 0, 0, 0, 0, 0, 0));
      addVec(BT_ST, 0, 0, ex(0, 1, lfSeq[i], 0, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      addVec(BT_ST | BT_RT, 0, 0, ex(0, 1, rtSeq[i], 0, 0, 0, 0, 0, 0, 0));
      addVec(BT_ST, 0, 0, ex(0, 1, rtSeq[i], 0, 0, 0, 0, 0, 0, 0));
    end
    addVec(BT_ST | BT_UP, 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST | BT_UP | BT_DN, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, zv);
    addVec(BT_MD, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_MD, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_UP, 0, 0, ex(2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec(BT_DN, 0, 0, ex(2, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(2, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    addVec(BT_ST, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    addVec(BT_ST, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST | BT_MD, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_MD, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST, 0, 0, ex(3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST | BT_UP, 0, 0, ex(3, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    addVec(BT_ST, 0, 0, ex(3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_UP, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addVec(6'd0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addVec(6'd0, 1, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    addVec(6'd0, 1, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    addVec(BT_LF, 1, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(6'd0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(BT_UP, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addVec(6'd0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addVec(BT_MD | BT_UP, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addVec(6'd0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].btn, vecs[i].zero, vecs[i].rst);
      checkOutput($sformatf("vec%0d", i), act & ~TICK_BIT, vecs[i].exp);
    end

    // Reset with a running timer, then measure tick spacing from reset
    applyStimulus(6'd0, 0, 1);
    checkOutput("reset_run", act, 13'd0);
    first = -1; second = -1; nTick = 0;
    for (int k = 1; k <= 35; k++) begin
      applyStimulus(6'd0, 0, 0);
      if (o_tick) begin
        nTick++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    checkOutput("tick_first", first, TICK_DIV);
    checkOutput("tick_period", second - first, TICK_DIV);
    checkOutput("tick_count", nTick, 3);

    // Holding set in CLOCK parks the prescaler; first tick after release is one period later
    applyStimulus(BT_ST, 0, 0);
    nTick = 0;
    for (int k = 0; k < 25; k++) begin
      applyStimulus(BT_ST, 0, 0);
      if (o_tick) nTick++;
    end
    checkOutput("tick_while_set", nTick, 0);
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(6'd0, 0, 0);
      if (o_tick && first < 0) first = k;
    end
    checkOutput("tick_after_set", first, TICK_DIV + 1);

    // Alarm self-clears after ALARM_SEC ticks
    for (int k = 0; k < 3; k++) begin
      applyStimulus(BT_MD, 0, 0);
      applyStimulus(6'd0, 0, 0);
    end
    checkOutput("timer_mode", o_mode, 2'd3);
    applyStimulus(BT_UP, 0, 0);
    applyStimulus(6'd0, 0, 0);
    checkOutput("timer_start", o_tmr_run, 1'b1);
    applyStimulus(6'd0, 1, 0);
    checkOutput("alarm_set", {o_tmr_run, o_tmr_alarm}, 2'b01);
    ticks = o_tick ? 1 : 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      applyStimulus(6'd0, 1, 0);
      if (!o_tmr_alarm) done = 1;
      else if (o_tick) ticks++;
    end
    checkOutput("alarm_timeout_seen", done, 1'b1);
    checkOutput("alarm_ticks", ticks, ALARM_SEC);

    // Reset in the middle of an alarm, with buttons held through the reset
    applyStimulus(BT_UP, 0, 0);
    applyStimulus(6'd0, 0, 0);
    applyStimulus(6'd0, 1, 0);
    checkOutput("alarm_again", o_tmr_alarm, 1'b1);
    applyStimulus(BT_UP | BT_LF, 0, 1);
    checkOutput("reset_alarm", act, 13'd0);
    applyStimulus(BT_UP | BT_LF, 0, 0);
    checkOutput("held_no_press", act & ~TICK_BIT, 13'd0);

    // Randomized buttons, set switch, timer-zero flag and occasional resets
    cur = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 2) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 11) == 0) cur[5] = ~cur[5];
      if ($urandom_range(0, 5) == 0) zero = ~zero;
      applyStimulus(cur, zero, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
